// File: rtl/line_byte_packer.sv
// line_byte_packer: assembles a byte stream into one 128-bit line with byte enables.
// Optional feature macro LINE_PACKER_LANE_SEL_EN adds explicit lane addressing (in_lane).
module line_byte_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 16,
  localparam int PW = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
`ifdef LINE_PACKER_LANE_SEL_EN
  input  logic [PW-1:0]          in_lane,
`endif
  output logic                   in_ready,
  output logic [WIDTH*LANES-1:0] line_data,
  output logic [LANES-1:0]       line_be,
  output logic                   line_valid,
  input  logic                   line_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic          wr;
  logic          lx;
  logic          close;
  logic [PW-1:0] lane;
  logic [LANES-1:0] be_nxt;

  assign in_ready   = (state == FILL);
  assign line_valid = (state == HOLD);
  assign wr = in_valid & in_ready;
  assign lx = line_valid & line_ready;

  assign be_nxt = line_be | (LANES'(1) << lane);

`ifdef LINE_PACKER_LANE_SEL_EN
  assign lane  = in_lane;
  assign close = (&be_nxt) | in_last;
`else
  logic [PW-1:0] ptr;
  assign lane  = ptr;
  assign close = (ptr == PW'(LANES-1)) | in_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      in_ready:   if (wr && close) state_nxt = HOLD;
      line_valid: if (lx) state_nxt = FILL;
    endcase
  end

  // single buffer: a line transfer clears it, no byte merges on that edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_data <= '0;
      line_be   <= '0;
`ifndef LINE_PACKER_LANE_SEL_EN
      ptr       <= '0;
`endif
    end else if (lx) begin
      line_data <= '0;
      line_be   <= '0;
`ifndef LINE_PACKER_LANE_SEL_EN
      ptr       <= '0;
`endif
    end else if (wr) begin
      line_data[lane*WIDTH +: WIDTH] <= in_data;
      line_be <= be_nxt;
`ifndef LINE_PACKER_LANE_SEL_EN
      ptr     <= ptr + 1'b1;
`endif
    end
  end

endmodule
